seq_signed_divider: RTL and testbench

- Multicycle signed 32-bit divider. It is the responder side of the DivInit/DivStop/DivZero handshake that the control unit drives.
- Operands come from the A and B registers. Remainder feeds the HI mux path; quotient feeds the LO mux path.
- Implements MIPS DIV semantics with a restoring shift-subtract algorithm, one quotient bit per clock.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_abs_neg.sv | 12 +
 rtl/seq_signed_divider.sv | 141 ++++++++++++++
 tb/tb_seq_signed_divider.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state encoding for the sequential signed divider
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;
  localparam int DIV_CNT_W   = $clog2(DIV_WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SIGN,
    ST_DONE,
    ST_ZERO
  } div_state_e;

endpackage

// File: rtl/div_abs_neg.sv
// rtl/div_abs_neg.sv - conditional two's-complement negate, modulo 2^WIDTH
module div_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - multicycle signed divider, restoring shift-subtract, one quotient bit per clock
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             div_init,
  output logic             div_stop,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_stop_q, div_stop_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_dividend (
    .a(dividend), .neg(dividend[WIDTH-1]), .y(dividend_mag)
  );
  div_abs_neg #(.WIDTH(WIDTH)) u_abs_divisor (
    .a(divisor), .neg(divisor[WIDTH-1]), .y(divisor_mag)
  );
  div_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .a(quo_q), .neg(q_neg_q), .y(quo_fix)
  );
  div_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .a(rem_q), .neg(r_neg_q), .y(rem_fix)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_stop_d = 1'b0;
    div_zero_d = 1'b0;
    // quo_q doubles as the dividend shift register: its MSB feeds the remainder
    rem_sh     = {rem_q, quo_q[WIDTH-1]};
    rem_ge     = rem_sh >= {1'b0, dvs_q};

    case (state_q)
      ST_IDLE: begin
        if (div_init) begin
          quo_d   = dividend_mag;
          dvs_d   = divisor_mag;
          q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          r_neg_d = dividend[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
          if (divisor == '0) begin
            state_d    = ST_ZERO;
            div_stop_d = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // remainder stays below the divisor, so the low WIDTH bits hold the exact difference
        quo_d = {quo_q[WIDTH-2:0], rem_ge};
        rem_d = rem_ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_SIGN;
        end
      end
      ST_SIGN: begin
        lo_d       = quo_fix;
        hi_d       = rem_fix;
        div_stop_d = 1'b1;
        state_d    = ST_DONE;
      end
      ST_DONE, ST_ZERO: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_stop_q <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_stop_q <= div_stop_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign div_stop = div_stop_q;
  assign div_zero = div_zero_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - directed self-checking bench for seq_signed_divider
module tb_seq_signed_divider;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        div_init = 1'b0;
  logic        div_stop, div_zero;
  logic [31:0] hi_out, lo_out;

  int n_checks = 0;
  int n_fail = 0;

  seq_signed_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .dividend(dividend), .divisor(divisor),
    .div_init(div_init), .div_stop(div_stop), .div_zero(div_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  // Issues one operation and waits (bounded) for div_stop; lat counts edges after E0.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic got, output logic zf,
                        output logic stop_after, output logic zero_after);
    dividend = a;
    divisor  = b;
    div_init = 1'b1;
    @(posedge clk); #1;
    div_init = 1'b0;
    dividend = 32'hDEADBEEF;
    divisor  = 32'h00000003;
    lat = 0;
    got = div_stop;
    while (!got && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      got = div_stop;
    end
    zf = div_zero;
    @(posedge clk); #1;
    stop_after = div_stop;
    zero_after = div_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (div_stop !== 1'b0) begin n_fail++; $display("FAIL reset_div_stop got=%b exp=0", div_stop); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
    n_checks++; if (hi_out !== 32'h0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi_out); end
    n_checks++; if (lo_out !== 32'h0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo_out); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic got, zf, sa, za;
    run_op(32'd7, 32'd2, lat, got, zf, sa, za);
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL basic_stop_seen got=%b exp=1", got); end
    n_checks++; if (lat != DIV_WIDTH + 1) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, DIV_WIDTH + 1); end
    n_checks++; if (zf !== 1'b0) begin n_fail++; $display("FAIL basic_div_zero got=%b exp=0", zf); end
    n_checks++; if (lo_out !== 32'd3) begin n_fail++; $display("FAIL basic_lo got=%h exp=3", lo_out); end
    n_checks++; if (hi_out !== 32'd1) begin n_fail++; $display("FAIL basic_hi got=%h exp=1", hi_out); end
    n_checks++; if (sa !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse got=%b exp=0", sa); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (lo_out !== 32'd3 || hi_out !== 32'd1) begin n_fail++; $display("FAIL basic_hold got=%h/%h exp=3/1", lo_out, hi_out); end
  endtask

  task automatic test_signs();
    logic [31:0] va [3] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9};
    logic [31:0] vb [3] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [31:0] el [3] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3};
    logic [31:0] eh [3] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF};
    int lat; logic got, zf, sa, za;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], lat, got, zf, sa, za);
      n_checks++; if (lat != DIV_WIDTH + 1) begin n_fail++; $display("FAIL signs_latency[%0d] got=%0d exp=%0d", i, lat, DIV_WIDTH + 1); end
      n_checks++; if (lo_out !== el[i]) begin n_fail++; $display("FAIL signs_lo[%0d] got=%h exp=%h", i, lo_out, el[i]); end
      n_checks++; if (hi_out !== eh[i]) begin n_fail++; $display("FAIL signs_hi[%0d] got=%h exp=%h", i, hi_out, eh[i]); end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic got, zf, sa, za;
    run_op(32'd7, 32'd2, lat, got, zf, sa, za);
    run_op(32'd5, 32'd0, lat, got, zf, sa, za);
    n_checks++; if (got !== 1'b1 || lat != 0) begin n_fail++; $display("FAIL zero_stop got=%b lat=%0d exp=1 lat=0", got, lat); end
    n_checks++; if (zf !== 1'b1) begin n_fail++; $display("FAIL zero_flag got=%b exp=1", zf); end
    n_checks++; if (lo_out !== 32'd3 || hi_out !== 32'd1) begin n_fail++; $display("FAIL zero_hold got=%h/%h exp=3/1", lo_out, hi_out); end
    n_checks++; if (sa !== 1'b0 || za !== 1'b0) begin n_fail++; $display("FAIL zero_pulse_width got=%b/%b exp=0/0", sa, za); end
    run_op(32'd9, 32'd3, lat, got, zf, sa, za);
    n_checks++; if (lat != DIV_WIDTH + 1 || lo_out !== 32'd3 || hi_out !== 32'd0) begin n_fail++; $display("FAIL zero_then_idle lat=%0d lo=%h hi=%h exp lat=%0d lo=3 hi=0", lat, lo_out, hi_out, DIV_WIDTH + 1); end
  endtask

  task automatic test_boundary();
    logic [31:0] va [4] = '{32'h80000000, 32'd5, 32'd0, 32'hFFFFFFFB};
    logic [31:0] vb [4] = '{32'hFFFFFFFF, 32'd9, 32'd5, 32'd9};
    logic [31:0] el [4] = '{32'h80000000, 32'd0, 32'd0, 32'd0};
    logic [31:0] eh [4] = '{32'd0, 32'd5, 32'd0, 32'hFFFFFFFB};
    int lat; logic got, zf, sa, za;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], lat, got, zf, sa, za);
      n_checks++; if (got !== 1'b1 || zf !== 1'b0) begin n_fail++; $display("FAIL bound_stop[%0d] got=%b zero=%b exp=1/0", i, got, zf); end
      n_checks++; if (lo_out !== el[i]) begin n_fail++; $display("FAIL bound_lo[%0d] got=%h exp=%h", i, lo_out, el[i]); end
      n_checks++; if (hi_out !== eh[i]) begin n_fail++; $display("FAIL bound_hi[%0d] got=%h exp=%h", i, hi_out, eh[i]); end
    end
  endtask

  task automatic test_ignore_init();
    int lat; logic got;
    dividend = 32'd100;
    divisor  = 32'd7;
    div_init = 1'b1;
    @(posedge clk); #1;
    div_init = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    dividend = 32'd9;
    divisor  = 32'd3;
    div_init = 1'b1;
    @(posedge clk); #1;
    div_init = 1'b0;
    lat = 10;
    got = div_stop;
    while (!got && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      got = div_stop;
    end
    n_checks++; if (got !== 1'b1 || lat != DIV_WIDTH + 1) begin n_fail++; $display("FAIL ignore_latency got=%b lat=%0d exp lat=%0d", got, lat, DIV_WIDTH + 1); end
    n_checks++; if (lo_out !== 32'd14) begin n_fail++; $display("FAIL ignore_lo got=%h exp=%h", lo_out, 32'd14); end
    n_checks++; if (hi_out !== 32'd2) begin n_fail++; $display("FAIL ignore_hi got=%h exp=2", hi_out); end
    @(posedge clk); #1;
    n_checks++; if (div_stop !== 1'b0) begin n_fail++; $display("FAIL ignore_single_pulse got=%b exp=0", div_stop); end
  endtask

  task automatic test_back_to_back();
    int lat; logic got, zf, sa, za;
    run_op(32'd9, 32'd3, lat, got, zf, sa, za);
    n_checks++; if (lat != DIV_WIDTH + 1 || lo_out !== 32'd3 || hi_out !== 32'd0) begin n_fail++; $display("FAIL b2b_first lat=%0d lo=%h hi=%h exp lat=%0d lo=3 hi=0", lat, lo_out, hi_out, DIV_WIDTH + 1); end
    run_op(32'hFFFFFF9C, 32'd7, lat, got, zf, sa, za);
    n_checks++; if (lat != DIV_WIDTH + 1) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, DIV_WIDTH + 1); end
    n_checks++; if (lo_out !== 32'hFFFFFFF2) begin n_fail++; $display("FAIL b2b_lo got=%h exp=fffffff2", lo_out); end
    n_checks++; if (hi_out !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL b2b_hi got=%h exp=fffffffe", hi_out); end
  endtask

  task automatic test_reset_abort();
    int lat; int seen; logic got, zf, sa, za;
    dividend = 32'd100;
    divisor  = 32'd7;
    div_init = 1'b1;
    @(posedge clk); #1;
    div_init = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (lo_out !== 32'h0 || hi_out !== 32'h0) begin n_fail++; $display("FAIL abort_results got=%h/%h exp=0/0", lo_out, hi_out); end
    n_checks++; if (div_stop !== 1'b0 || div_zero !== 1'b0) begin n_fail++; $display("FAIL abort_flags got=%b/%b exp=0/0", div_stop, div_zero); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (div_stop) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_stop got=%0d pulses exp=0", seen); end
    run_op(32'd9, 32'd3, lat, got, zf, sa, za);
    n_checks++; if (lat != DIV_WIDTH + 1 || lo_out !== 32'd3 || hi_out !== 32'd0) begin n_fail++; $display("FAIL abort_recover lat=%0d lo=%h hi=%h exp lat=%0d lo=3 hi=0", lat, lo_out, hi_out, DIV_WIDTH + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_boundary();
    test_ignore_init();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
